// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Hazard controller for a five-stage in-order pipeline. Produces the
//   stall/flush controls for F, D and E. It also sequences a multi-cycle
//   iterative divider that occupies E, and keeps two 32-bit event counters.
//
// Parameters
//   DIV_LAT        divide/remainder occupancy of E in cycles (2..64)
//
// Ports
//   clk            clock, rising edge
//   reset          synchronous, active-high reset
//   rs1D, rs2D     source registers of the instruction in D
//   rdE            destination register of the instruction in E
//   memreadE       instruction in E is a load
//   divE           instruction in E is DIV/DIVU/REM/REMU
//   branch_takenE  branch/jump in E redirects the PC
//   stallF         hold the PC register
//   stallD         hold the IF/ID register
//   stallE         hold the ID/EX register
//   flushD         clear IF/ID on the next edge
//   flushE         bubble into ID/EX on the next edge
//   div_start      one-cycle launch pulse for the divider
//   div_done       divider result valid, E advances this cycle
//   stall_cnt      number of cycles with stallF=1 (wrapping)
//   flush_cnt      number of cycles with flushD or flushE (wrapping)
module pipe_hazard_ctrl #(
  parameter int DIV_LAT = 34
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs1D,
  input  logic [4:0]  rs2D,
  input  logic [4:0]  rdE,
  input  logic        memreadE,
  input  logic        divE,
  input  logic        branch_takenE,
  output logic        stallF,
  output logic        stallD,
  output logic        stallE,
  output logic        flushD,
  output logic        flushE,
  output logic        div_start,
  output logic        div_done,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of BUSY cycles that follow the launch cycle. Launch cycle plus
  // BUSY cycles make up the DIV_LAT-1 stalled cycles. DONE is the last cycle.
  localparam logic [5:0] LOAD_VAL = 6'(DIV_LAT - 2);

  state_t      state_r;
  logic [5:0]  div_cnt_r;
  logic        div_busy_s;
  logic        lw_s;

  // Hazard detection and stall/flush priority: divider, then branch, then load-use
  always_comb begin
    div_busy_s = 1'b0;
    lw_s       = 1'b0;
    stallF     = 1'b0;
    stallD     = 1'b0;
    stallE     = 1'b0;
    flushD     = 1'b0;
    flushE     = 1'b0;
    div_start  = 1'b0;
    div_done   = 1'b0;

    div_start  = (state_r == IDLE) && divE;
    div_done   = (state_r == DONE);
    div_busy_s = div_start || (state_r == BUSY);
    lw_s       = memreadE && (rdE != 5'd0) && ((rdE == rs1D) || (rdE == rs2D));

    if (div_busy_s) begin
      // The divide in E must never be killed, so flushes are held off.
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
    end else if (branch_takenE) begin
      // The redirect discards the dependent instruction, so no load-use stall is needed.
      flushD = 1'b1;
      flushE = 1'b1;
    end else if (lw_s) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end else begin
      stallF = 1'b0;
      stallD = 1'b0;
    end
  end

  // Divider occupancy FSM with BUSY down-counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      div_cnt_r <= 6'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (divE) begin
            div_cnt_r <= LOAD_VAL;
            // With DIV_LAT=2 the launch cycle is the only stalled cycle.
            state_r   <= (LOAD_VAL == 6'd0) ? DONE : BUSY;
          end else begin
            state_r   <= IDLE;
          end
        end
        BUSY: begin
          // Leave when the decremented count reaches zero. The <= guard
          // also gets out of an unreachable zero count.
          div_cnt_r <= div_cnt_r - 6'd1;
          if (div_cnt_r <= 6'd1) begin
            state_r <= DONE;
          end else begin
            state_r <= BUSY;
          end
        end
        DONE: begin
          // divE may still be high here. A following divide launches from IDLE.
          state_r   <= IDLE;
          div_cnt_r <= 6'd0;
        end
        default: begin
          state_r   <= IDLE;
          div_cnt_r <= 6'd0;
        end
      endcase
    end
  end

  // Stall and flush event counters; a cycle that does both bumps both
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (stallF) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (flushD || flushE) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl. Table vectors cover the combinational
// hazard decode. Hand-built sequences cover the divider: a single divide,
// back-to-back divides, and reset during BUSY. The expected output flags go
// into a queue when a cycle is driven. They are popped and compared at the
// falling edge. The counters are checked against a bench-side running model.
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  rs1D;
  logic [4:0]  rs2D;
  logic [4:0]  rdE;
  logic        memreadE;
  logic        divE;
  logic        branch_takenE;
  logic        stallF;
  logic        stallD;
  logic        stallE;
  logic        flushD;
  logic        flushE;
  logic        div_start;
  logic        div_done;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  pipe_hazard_ctrl #(.DIV_LAT(34)) dut (
    .clk           (clk),
    .reset         (reset),
    .rs1D          (rs1D),
    .rs2D          (rs2D),
    .rdE           (rdE),
    .memreadE      (memreadE),
    .divE          (divE),
    .branch_takenE (branch_takenE),
    .stallF        (stallF),
    .stallD        (stallD),
    .stallE        (stallE),
    .flushD        (flushD),
    .flushE        (flushE),
    .div_start     (div_start),
    .div_done      (div_done),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       memread;
    logic       div;
    logic       br;
  } in_t;

  // Flags packed as {stallF, stallD, stallE, flushD, flushE, div_start, div_done}
  typedef struct {
    in_t        in;
    logic [6:0] exp;
    string      name;
  } vec_t;

  localparam logic [6:0] F_NONE  = 7'b0000000;
  localparam logic [6:0] F_LW    = 7'b1100100;
  localparam logic [6:0] F_BR    = 7'b0001100;
  localparam logic [6:0] F_START = 7'b1110010;
  localparam logic [6:0] F_BUSY  = 7'b1110000;
  localparam logic [6:0] F_DONE  = 7'b0000001;

  logic [6:0]  exp_q[$];
  logic [31:0] m_stall;
  logic [31:0] m_flush;
  int          n_checks;
  int          n_fail;
  vec_t        tbl[8];

  function automatic in_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rd, input logic memread,
                             input logic div, input logic br);
    in_t t;
    t.rs1 = rs1; t.rs2 = rs2; t.rd = rd;
    t.memread = memread; t.div = div; t.br = br;
    return t;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle. Check the flags mid-cycle, then the counters after the edge.
  task automatic step(input in_t i, input logic rst, input logic [6:0] e, input string name);
    logic [6:0] want;
    logic [6:0] got;
    rs1D = i.rs1; rs2D = i.rs2; rdE = i.rd;
    memreadE = i.memread; divE = i.div; branch_takenE = i.br;
    reset = rst;
    exp_q.push_back(e);
    @(negedge clk);
    want = exp_q.pop_front();
    got  = {stallF, stallD, stallE, flushD, flushE, div_start, div_done};
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s flags: got %b, expected %b at %0t", name, got, want, $time);
    end
    @(posedge clk);
    if (rst) begin
      m_stall = 32'd0;
      m_flush = 32'd0;
    end else begin
      if (e[6]) m_stall = m_stall + 32'd1;
      if (e[3] || e[2]) m_flush = m_flush + 32'd1;
    end
    #1;
    check32({name, " stall_cnt"}, stall_cnt, m_stall);
    check32({name, " flush_cnt"}, flush_cnt, m_flush);
  endtask

  initial begin
    in_t         z;
    in_t         dv;
    in_t         t;
    logic [31:0] s0;
    n_checks = 0;
    n_fail   = 0;
    m_stall  = 32'd0;
    m_flush  = 32'd0;
    z  = mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    dv = mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);

    tbl[0] = '{mk(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0), F_LW,   "lw_rs1"};
    tbl[1] = '{mk(5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0), F_NONE, "lw_x0"};
    tbl[2] = '{mk(5'd7, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0), F_LW,   "lw_rs2"};
    tbl[3] = '{mk(5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0), F_NONE, "not_load"};
    tbl[4] = '{mk(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0), F_NONE, "rd_mismatch"};
    tbl[5] = '{mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1), F_BR,   "branch"};
    tbl[6] = '{mk(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1), F_BR,   "branch_lw"};
    tbl[7] = '{mk(5'd31, 5'd4, 5'd31, 1'b1, 1'b0, 1'b0), F_LW, "lw_r31"};

    // Reset with all inputs low: every output is zero
    step(z, 1'b1, F_NONE, "reset0");
    step(z, 1'b1, F_NONE, "reset1");

    // Combinational hazard decode from IDLE
    for (int k = 0; k < 8; k++) begin
      step(tbl[k].in, 1'b0, tbl[k].exp, tbl[k].name);
    end

    // Single divide: 33 stalled cycles, then done. A load-use and a branch
    // arriving mid-divide must not flush.
    s0 = m_stall;
    for (int c = 0; c <= 34; c++) begin
      t = dv;
      if (c == 5) t = mk(5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
      if (c == 6) t = mk(5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1);
      if (c == 34) t = z;
      step(t, 1'b0, (c == 0) ? F_START : (c < 33) ? F_BUSY : (c == 33) ? F_DONE : F_NONE,
           $sformatf("div1_c%0d", c));
    end
    check32("div1 stall delta", m_stall - s0, 32'd33);
    check32("div1 stall_cnt", stall_cnt - s0, 32'd33);

    // Back-to-back: divE held high across DONE, relaunch on the next cycle
    for (int c = 0; c <= 68; c++) begin
      step((c == 68) ? z : dv, 1'b0,
           (c == 0 || c == 34) ? F_START :
           (c == 33 || c == 67) ? F_DONE :
           (c == 68) ? F_NONE : F_BUSY,
           $sformatf("b2b_c%0d", c));
    end

    // Reset in BUSY cycle 10: abort to IDLE, no done pulse afterwards
    for (int c = 0; c <= 45; c++) begin
      step((c <= 10) ? dv : z, (c == 10),
           (c == 0) ? F_START : (c <= 10) ? F_BUSY : F_NONE,
           $sformatf("rstbusy_c%0d", c));
    end
    check32("rstbusy stall_cnt", stall_cnt, 32'd0);

    // Hazards still decode correctly after the aborted divide
    step(tbl[0].in, 1'b0, F_LW, "post_lw");
    step(tbl[6].in, 1'b0, F_BR, "post_br_lw");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
